// File: rtl/latch_seq_pkg.sv
// latch_seq_pkg: shared definitions for the latch command sequencer.
//   - command op encodings
//   - sequencer FSM state type
//   - CHECK phase length (2 synchronizer cycles + 1 compare cycle)
//   - helpers for phase counter sizing and the expected readback value
package latch_seq_pkg;

   localparam logic [1:0] OP_WRITE = 2'd0;
   localparam logic [1:0] OP_SET   = 2'd1;
   localparam logic [1:0] OP_CLEAR = 2'd2;
   localparam logic [1:0] OP_READ  = 2'd3;

   localparam int unsigned CHECK_CYC = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_CHECK
   } state_t;

   function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   // Value the latch should hold once the command has completed.
   // READ has no expectation; callers mask the compare for it.
   function automatic logic expected_q(input logic [1:0] op, input logic d);
      logic e;
      case (op)
         OP_SET:   e = 1'b1;
         OP_CLEAR: e = 1'b0;
         default:  e = d;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/latch_seq_sync2.sv
// latch_seq_sync2: two-flop synchronizer for the asynchronous latch output.
// Ports:
//   clk  - sampling clock
//   clr  - asynchronous active-low reset, both flops to 0
//   d    - asynchronous input
//   q    - synchronized output
module latch_seq_sync2 (
   input  logic clk,
   input  logic clr,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/latch_seq.sv
// latch_seq: command sequencer for a level-sensitive latch bank with async
// set/clear. Each command is turned into a setup / pulse / hold sequence on
// the latch pins, followed by a synchronized readback compare.
// Ports:
//   clk        - clock, rising edge
//   clr        - asynchronous active-low reset
//   cmd_valid  - command offered
//   cmd_ready  - sequencer idle; command taken on valid && ready
//   cmd_op     - WRITE / SET / CLEAR / READ
//   cmd_d      - data for WRITE
//   lat_en     - latch enable   (active-low when INV_CTRL)
//   lat_pre    - latch preset   (active-low when INV_CTRL)
//   lat_clr    - latch clear    (active-low when INV_CTRL)
//   lat_d      - latch data
//   lat_q      - latch output, asynchronous to clk
//   rsp_valid  - one-cycle status pulse
//   rsp_q      - synchronized lat_q captured at compare
//   rsp_err    - readback differed from expected (with rsp_valid)
//   err_clr    - synchronous clear of err_cnt (wins over increment)
//   err_cnt    - saturating mismatch count
module latch_seq
   import latch_seq_pkg::*;
#(
   parameter int unsigned SETUP_CYC = 1,
   parameter int unsigned PULSE_CYC = 2,
   parameter int unsigned HOLD_CYC  = 1,
   parameter int unsigned CNT_W     = 8,
   parameter bit          INV_CTRL  = 1'b0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic             cmd_d,
   output logic             lat_en,
   output logic             lat_pre,
   output logic             lat_clr,
   output logic             lat_d,
   input  logic             lat_q,
   output logic             rsp_valid,
   output logic             rsp_q,
   output logic             rsp_err,
   input  logic             err_clr,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int unsigned PW = $clog2(max4(SETUP_CYC, PULSE_CYC, HOLD_CYC, CHECK_CYC)) + 1;

   localparam logic [PW-1:0] SETUP_LAST = PW'(SETUP_CYC - 1);
   localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYC - 1);
   localparam logic [PW-1:0] HOLD_LAST  = PW'(HOLD_CYC - 1);
   localparam logic [PW-1:0] CHECK_LAST = PW'(CHECK_CYC - 1);

   state_t          state, state_n;
   logic [PW-1:0]   cnt, cnt_n;
   logic [1:0]      op_r;
   logic            d_r;
   logic            q_s;
   logic            take;
   logic            fire;
   logic            mism;

   latch_seq_sync2 u_sync (
      .clk (clk),
      .clr (clr),
      .d   (lat_q),
      .q   (q_s)
   );

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      take    = cmd_valid && cmd_ready;
      fire    = (state == ST_CHECK) && (cnt == CHECK_LAST);
      mism    = (op_r != OP_READ) && (q_s != expected_q(op_r, d_r));
      unique case (state)
         ST_IDLE: begin
            cnt_n = '0;
            if (take) state_n = (cmd_op == OP_READ) ? ST_CHECK : ST_SETUP;
         end
         ST_SETUP: if (cnt == SETUP_LAST) begin
            state_n = ST_PULSE;
            cnt_n   = '0;
         end
         ST_PULSE: if (cnt == PULSE_LAST) begin
            state_n = ST_HOLD;
            cnt_n   = '0;
         end
         ST_HOLD: if (cnt == HOLD_LAST) begin
            state_n = ST_CHECK;
            cnt_n   = '0;
         end
         ST_CHECK: if (fire) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
         end
         default: begin
            state_n = ST_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // Pins and status are registered from the current state, so they trail
   // the FSM by one cycle: no combinational path reaches the latch pins, and
   // the single-op decode guarantees at most one control is ever active.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         op_r      <= OP_WRITE;
         d_r       <= 1'b0;
         cmd_ready <= 1'b0;
         lat_d     <= 1'b0;
         lat_en    <= INV_CTRL;
         lat_pre   <= INV_CTRL;
         lat_clr   <= INV_CTRL;
         rsp_valid <= 1'b0;
         rsp_q     <= 1'b0;
         rsp_err   <= 1'b0;
         err_cnt   <= '0;
      end else begin
         cmd_ready <= (state == ST_IDLE) && !take;
         if (take) begin
            op_r <= cmd_op;
            d_r  <= cmd_d;
         end
         if ((state == ST_SETUP) && (op_r == OP_WRITE)) lat_d <= d_r;
         lat_en  <= INV_CTRL ^ ((state == ST_PULSE) && (op_r == OP_WRITE));
         lat_pre <= INV_CTRL ^ ((state == ST_PULSE) && (op_r == OP_SET));
         lat_clr <= INV_CTRL ^ ((state == ST_PULSE) && (op_r == OP_CLEAR));
         rsp_valid <= fire;
         if (fire) rsp_q <= q_s;
         rsp_err <= fire && mism;
         if (err_clr) begin
            err_cnt <= '0;
         end else if (rsp_valid && rsp_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_latch_seq.sv
module tb_latch_seq;
   import latch_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst;

   // DUT0: active-high controls
   logic       v0, r0, d0, en0, pre0, clp0, ld0, lq0, rv0, rq0, re0, eclr0;
   logic [1:0] op0;
   logic [7:0] ecnt0;
   // DUT1: active-low controls
   logic       v1, r1, d1, en1, pre1, clp1, ld1, lq1, rv1, rq1, re1, eclr1;
   logic [1:0] op1;
   logic [7:0] ecnt1;

   logic       fault;
   logic       q0_m, q1_m;

   int n_vec = 0;
   int n_err = 0;

   // monitor counters
   int  pre_hi = 0, clr_hi = 0, pre_rise = 0, clr_rise = 0, rsp_cnt = 0, en1_lo = 0;
   bit  pre_prev = 1'b0, clr_prev = 1'b0, ovl0 = 1'b0, ovl1 = 1'b0;

   always #5 clk = ~clk;

   latch_seq #(.SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1), .CNT_W(8), .INV_CTRL(1'b0)) dut0 (
      .clk(clk), .clr(rst), .cmd_valid(v0), .cmd_ready(r0), .cmd_op(op0), .cmd_d(d0),
      .lat_en(en0), .lat_pre(pre0), .lat_clr(clp0), .lat_d(ld0), .lat_q(lq0),
      .rsp_valid(rv0), .rsp_q(rq0), .rsp_err(re0), .err_clr(eclr0), .err_cnt(ecnt0)
   );

   latch_seq #(.SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1), .CNT_W(8), .INV_CTRL(1'b1)) dut1 (
      .clk(clk), .clr(rst), .cmd_valid(v1), .cmd_ready(r1), .cmd_op(op1), .cmd_d(d1),
      .lat_en(en1), .lat_pre(pre1), .lat_clr(clp1), .lat_d(ld1), .lat_q(lq1),
      .rsp_valid(rv1), .rsp_q(rq1), .rsp_err(re1), .err_clr(eclr1), .err_cnt(ecnt1)
   );

   // behavioural latches: preset, then clear, then transparent enable
   always_latch begin
      if (pre0)      q0_m = 1'b1;
      else if (clp0) q0_m = 1'b0;
      else if (en0)  q0_m = ld0;
   end

   always_latch begin
      if (!pre1)      q1_m = 1'b1;
      else if (!clp1) q1_m = 1'b0;
      else if (!en1)  q1_m = ld1;
   end

   assign lq0 = fault ? 1'b0 : q0_m;
   assign lq1 = q1_m;

   always @(negedge clk) begin
      if ((en0 && pre0) || (en0 && clp0) || (pre0 && clp0)) ovl0 = 1'b1;
      if ((!en1 && !pre1) || (!en1 && !clp1) || (!pre1 && !clp1)) ovl1 = 1'b1;
      if (pre0) pre_hi++;
      if (clp0) clr_hi++;
      if (pre0 && !pre_prev) pre_rise++;
      if (clp0 && !clr_prev) clr_rise++;
      pre_prev = pre0;
      clr_prev = clp0;
      if (rv0) rsp_cnt++;
      if (!en1) en1_lo++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one command on the selected DUT and wait for its response.
   // Returns with the bench sitting in the rsp_valid cycle.
   task automatic do_cmd(input bit sel, input logic [1:0] op, input logic d,
                         input int exp_lat, output logic q, output logic err);
      int k;
      k = 0;
      while (!(sel ? r1 : r0) && k < 20) begin
         tick();
         k++;
      end
      chk("cmd_ready_wait", {31'd0, sel ? r1 : r0}, 32'd1);
      if (sel) begin v1 = 1'b1; op1 = op; d1 = d; end
      else     begin v0 = 1'b1; op0 = op; d0 = d; end
      tick();
      v0 = 1'b0; v1 = 1'b0;
      d0 = ~d;   d1 = ~d;
      k = 0;
      do begin
         tick();
         k++;
      end while (!(sel ? rv1 : rv0) && k < 20);
      chk("rsp_latency", k, exp_lat);
      q   = sel ? rq1 : rq0;
      err = sel ? re1 : re0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic q, e;
      int   k, s_pre_hi, s_clr_hi, s_pre_rise, s_clr_rise, s_rsp, s_en1;

      rst = 1'b0; fault = 1'b0;
      v0 = 1'b0; op0 = OP_WRITE; d0 = 1'b0; eclr0 = 1'b0;
      v1 = 1'b0; op1 = OP_WRITE; d1 = 1'b0; eclr1 = 1'b0;

      // ---- reset values
      #12;
      chk("rst_en",     {31'd0, en0}, 0);
      chk("rst_pre",    {31'd0, pre0}, 0);
      chk("rst_clr",    {31'd0, clp0}, 0);
      chk("rst_d",      {31'd0, ld0}, 0);
      chk("rst_ready",  {31'd0, r0}, 0);
      chk("rst_rsp",    {31'd0, rv0}, 0);
      chk("rst_errcnt", {24'd0, ecnt0}, 0);
      chk("rst_inv_idle", {29'd0, en1, pre1, clp1}, 3'b111);
      rst = 1'b1;
      #1;
      chk("ready_before_edge", {31'd0, r0}, 0);
      tick();
      chk("ready_after_release", {31'd0, r0}, 1);

      // ---- WRITE d=1, cycle-accurate pin timing
      v0 = 1'b1; op0 = OP_WRITE; d0 = 1'b1;
      tick();                                   // edge T
      v0 = 1'b0; d0 = 1'b0;
      chk("w_ready_drop", {31'd0, r0}, 0);
      chk("w_d_T",        {31'd0, ld0}, 0);
      tick();                                   // T+1
      chk("w_d_T1",       {31'd0, ld0}, 1);
      chk("w_en_T1",      {31'd0, en0}, 0);
      tick();                                   // T+2
      chk("w_en_T2",      {31'd0, en0}, 1);
      tick();                                   // T+3
      chk("w_en_T3",      {31'd0, en0}, 1);
      chk("w_pre_T3",     {31'd0, pre0}, 0);
      tick();                                   // T+4
      chk("w_en_T4",      {31'd0, en0}, 0);
      chk("w_d_hold",     {31'd0, ld0}, 1);
      tick(); tick();                           // T+6
      chk("w_rsp_T6",     {31'd0, rv0}, 0);
      tick();                                   // T+7
      chk("w_rsp_T7",     {31'd0, rv0}, 1);
      chk("w_rsp_q",      {31'd0, rq0}, 1);
      chk("w_rsp_err",    {31'd0, re0}, 0);
      tick();                                   // T+8
      chk("w_rsp_T8",     {31'd0, rv0}, 0);
      chk("w_ready_T8",   {31'd0, r0}, 1);
      chk("w_errcnt",     {24'd0, ecnt0}, 0);

      // ---- back-to-back SET then CLEAR with cmd_valid held
      s_pre_hi = pre_hi; s_clr_hi = clr_hi; s_pre_rise = pre_rise; s_clr_rise = clr_rise;
      v0 = 1'b1; op0 = OP_SET;
      tick();                                   // SET accepted
      op0 = OP_CLEAR;
      k = 0;
      do begin tick(); k++; end while (!rv0 && k < 20);
      chk("b2b_set_lat", k, 7);
      chk("b2b_set_q",   {31'd0, rq0}, 1);
      chk("b2b_set_err", {31'd0, re0}, 0);
      tick();
      chk("b2b_ready_back", {31'd0, r0}, 1);
      tick();                                   // CLEAR accepted
      chk("b2b_accept2", {31'd0, r0}, 0);
      v0 = 1'b0;
      k = 0;
      do begin tick(); k++; end while (!rv0 && k < 20);
      chk("b2b_clr_lat", k, 7);
      chk("b2b_clr_q",   {31'd0, rq0}, 0);
      chk("b2b_clr_err", {31'd0, re0}, 0);
      chk("b2b_pre_pulses", pre_rise - s_pre_rise, 1);
      chk("b2b_pre_cycles", pre_hi - s_pre_hi, 2);
      chk("b2b_clr_pulses", clr_rise - s_clr_rise, 1);
      chk("b2b_clr_cycles", clr_hi - s_clr_hi, 2);

      // ---- fault: lat_q stuck at 0
      fault = 1'b1;
      do_cmd(1'b0, OP_WRITE, 1'b1, 7, q, e);
      chk("flt_q",   {31'd0, q}, 0);
      chk("flt_err", {31'd0, e}, 1);
      tick();
      chk("flt_cnt1", {24'd0, ecnt0}, 1);
      for (int i = 0; i < 300; i++) do_cmd(1'b0, OP_SET, 1'b0, 7, q, e);
      tick();
      chk("flt_sat", {24'd0, ecnt0}, 255);
      do_cmd(1'b0, OP_WRITE, 1'b1, 7, q, e);
      chk("flt_err_at_clr", {31'd0, e}, 1);
      eclr0 = 1'b1;
      tick();
      eclr0 = 1'b0;
      chk("flt_clr_wins", {24'd0, ecnt0}, 0);
      do_cmd(1'b0, OP_READ, 1'b1, 3, q, e);
      chk("read_q",   {31'd0, q}, 0);
      chk("read_err", {31'd0, e}, 0);
      tick();
      chk("read_cnt", {24'd0, ecnt0}, 0);
      do_cmd(1'b0, OP_WRITE, 1'b1, 7, q, e);
      tick();
      chk("flt_cnt_again", {24'd0, ecnt0}, 1);
      fault = 1'b0;

      // ---- reset in the middle of the pulse
      v0 = 1'b1; op0 = OP_WRITE; d0 = 1'b1;
      tick();
      v0 = 1'b0;
      tick(); tick();                           // T+2
      chk("mid_en_active", {31'd0, en0}, 1);
      s_rsp = rsp_cnt;
      #2 rst = 1'b0;
      #1;
      chk("mid_en_drop", {31'd0, en0}, 0);
      chk("mid_d",       {31'd0, ld0}, 0);
      chk("mid_ready",   {31'd0, r0}, 0);
      chk("mid_errcnt",  {24'd0, ecnt0}, 0);
      tick(); tick(); tick();
      rst = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      chk("mid_no_rsp", rsp_cnt - s_rsp, 0);
      chk("mid_ready_back", {31'd0, r0}, 1);

      // ---- inverted controls with active-low latch
      chk("inv_idle", {29'd0, en1, pre1, clp1}, 3'b111);
      do_cmd(1'b1, OP_SET, 1'b0, 7, q, e);
      chk("inv_set_q",   {31'd0, q}, 1);
      chk("inv_set_err", {31'd0, e}, 0);
      s_en1 = en1_lo;
      do_cmd(1'b1, OP_WRITE, 1'b0, 7, q, e);
      chk("inv_w_q",     {31'd0, q}, 0);
      chk("inv_w_err",   {31'd0, e}, 0);
      chk("inv_en_low_cycles", en1_lo - s_en1, 2);
      tick();
      chk("inv_idle_after", {29'd0, en1, pre1, clp1}, 3'b111);
      chk("inv_errcnt", {24'd0, ecnt1}, 0);

      chk("no_overlap0", {31'd0, ovl0}, 0);
      chk("no_overlap1", {31'd0, ovl1}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
